// File: rtl/seq_or_monitor.sv
// Runtime monitor for the property "(a ##1 a) or (!b[*3] ##1 b[*2])" launched on each rising start.
// Verdict pulses appear one cycle after the deciding edge; attempts last at most four edges past T0.
module seq_or_monitor (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       a,
  input  logic       b,
  input  logic       clr,
  output logic       pass,
  output logic       fail,
  output logic       busy,
  output logic       ovr,
  output logic [7:0] pass_cnt,
  output logic [7:0] fail_cnt
);

  typedef enum logic {IDLE, RUN} state_t;

  // Step index (relative to T0) of each sub-sequence's final element.
  localparam logic [2:0] SEQ1_LAST = 3'd1;
  localparam logic [2:0] SEQ2_LAST = 3'd4;
  localparam logic [2:0] SEQ2_B_HI = 3'd3;
  localparam logic [7:0] CNT_MAX   = 8'hFF;

  state_t     state_q, state_d;
  logic [2:0] step_q, step_d;
  logic       live1_q, live1_d;
  logic       live2_q, live2_d;
  logic       start_q;
  logic       armed_q;
  logic       pass_q, fail_q;
  logic       ovr_q;
  logic [7:0] pass_cnt_q, fail_cnt_q;

  logic       trig;
  logic       ok1, ok2;
  logic       m1, m2;
  logic       n1, n2;
  logic       v_pass, v_fail;
  logic       ovr_set;

  // armed_q blocks a start that was already high when reset released.
  assign trig = start & ~start_q & armed_q;

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    live1_d = live1_q;
    live2_d = live2_q;
    ok1     = 1'b0;
    ok2     = 1'b0;
    m1      = 1'b0;
    m2      = 1'b0;
    n1      = 1'b0;
    n2      = 1'b0;
    v_pass  = 1'b0;
    v_fail  = 1'b0;
    ovr_set = 1'b0;

    case (state_q)
      IDLE: begin
        if (trig) begin
          if (!a && b) begin
            v_fail = 1'b1;
          end else begin
            state_d = RUN;
            step_d  = 3'd1;
            live1_d = a;
            live2_d = ~b;
          end
        end
      end

      RUN: begin
        ovr_set = trig;
        ok1 = live1_q && a;
        ok2 = live2_q && (b == (step_q >= SEQ2_B_HI));
        m1  = ok1 && (step_q == SEQ1_LAST);
        m2  = ok2 && (step_q == SEQ2_LAST);
        n1  = ok1 && (step_q < SEQ1_LAST);
        n2  = ok2 && (step_q < SEQ2_LAST);

        // A match on either branch wins even if the other branch dies on the same edge.
        if (m1 || m2) begin
          v_pass = 1'b1;
        end else if (!n1 && !n2) begin
          v_fail = 1'b1;
        end

        if (v_pass || v_fail) begin
          state_d = IDLE;
          step_d  = 3'd0;
          live1_d = 1'b0;
          live2_d = 1'b0;
        end else begin
          step_d  = step_q + 3'd1;
          live1_d = n1;
          live2_d = n2;
        end
      end

      default: begin
        state_d = IDLE;
        step_d  = 3'd0;
        live1_d = 1'b0;
        live2_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      step_q  <= 3'd0;
      live1_q <= 1'b0;
      live2_q <= 1'b0;
      start_q <= 1'b0;
      armed_q <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      live1_q <= live1_d;
      live2_q <= live2_d;
      start_q <= start;
      if (!start) begin
        armed_q <= 1'b1;
      end
      pass_q  <= v_pass;
      fail_q  <= v_fail;
    end
  end

  // Clear outranks any same-cycle increment or overrun set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovr_q      <= 1'b0;
      pass_cnt_q <= 8'd0;
      fail_cnt_q <= 8'd0;
    end else if (clr) begin
      ovr_q      <= 1'b0;
      pass_cnt_q <= 8'd0;
      fail_cnt_q <= 8'd0;
    end else begin
      if (ovr_set) begin
        ovr_q <= 1'b1;
      end
      if (v_pass && (pass_cnt_q != CNT_MAX)) begin
        pass_cnt_q <= pass_cnt_q + 8'd1;
      end
      if (v_fail && (fail_cnt_q != CNT_MAX)) begin
        fail_cnt_q <= fail_cnt_q + 8'd1;
      end
    end
  end

  assign pass     = pass_q;
  assign fail     = fail_q;
  assign busy     = (state_q == RUN);
  assign ovr      = ovr_q;
  assign pass_cnt = pass_cnt_q;
  assign fail_cnt = fail_cnt_q;

endmodule

// File: tb/tb_seq_or_monitor.sv
// Scoreboard bench for seq_or_monitor: directed attempts push expected verdicts, a monitor pops them.
module tb_seq_or_monitor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       a = 1'b0;
  logic       b = 1'b0;
  logic       clr = 1'b0;
  logic       pass, fail, busy, ovr;
  logic [7:0] pass_cnt, fail_cnt;

  seq_or_monitor dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .clr(clr),
    .pass(pass), .fail(fail), .busy(busy), .ovr(ovr),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit is_pass;
    int vedge;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   run_len = 0;
  int   last_run = 0;
  int   max_run = 0;
  int   exp_pass = 0;
  int   exp_fail = 0;
  logic busy_k1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: verdict pulses are matched against the scoreboard in order.
  always @(negedge clk) begin
    exp_t e;
    if (busy) begin
      run_len++;
      if (run_len > max_run) max_run = run_len;
    end else begin
      if (run_len > 0) last_run = run_len;
      run_len = 0;
    end
    if (pass || fail) begin
      checks++;
      if (pass && fail) begin
        failures++;
        $display("FAIL pulse_both: pass=1 fail=1 at edge %0d, required one-hot", cyc);
      end else if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_verdict: pass=%0d fail=%0d at edge %0d, required none", pass, fail, cyc);
      end else begin
        e = exp_q.pop_front();
        if (e.is_pass != pass || e.vedge != cyc) begin
          failures++;
          $display("FAIL verdict: got pass=%0d at edge %0d, required pass=%0d at edge %0d",
                   pass, cyc, e.is_pass, e.vedge);
        end
      end
    end
  end

  task automatic step(input logic s, input logic av, input logic bv, input logic c);
    @(negedge clk);
    start = s;
    a     = av;
    b     = bv;
    clr   = c;
  endtask

  // Bit k of each vector is driven for edge T0+k; the verdict edge is T0+off.
  task automatic attempt(input logic [4:0] sv, input logic [4:0] av, input logic [4:0] bv,
                         input bit is_pass, input int off);
    exp_t e;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      step(sv[k], av[k], bv[k], 1'b0);
      if (k == 0) begin
        e.is_pass = is_pass;
        e.vedge   = cyc + 1 + off;
        exp_q.push_back(e);
        if (is_pass) exp_pass = (exp_pass < 255) ? exp_pass + 1 : 255;
        else         exp_fail = (exp_fail < 255) ? exp_fail + 1 : 255;
      end
      if (k == 1) busy_k1 = busy;
    end
  endtask

  task automatic settle();
    repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_outputs", int'({pass, fail, busy, ovr, pass_cnt, fail_cnt}), 0);
    rst_n = 1'b1;
    settle();

    // Both branches would match; seq1 decides at T0+1.
    attempt(5'b00001, 5'b00011, 5'b11000, 1'b1, 1);
    settle();
    chk("both_true_pass_cnt", int'(pass_cnt), exp_pass);
    chk("both_true_busy_run", last_run, 1);

    // seq1 dies at T0+1, seq2 carries the attempt to T0+4.
    attempt(5'b00001, 5'b00001, 5'b11000, 1'b1, 4);
    settle();
    chk("seq2_only_busy_run", last_run, 4);
    chk("seq2_only_pass_cnt", int'(pass_cnt), exp_pass);

    attempt(5'b00001, 5'b00001, 5'b01000, 1'b0, 4);
    settle();
    chk("both_false_fail_cnt", int'(fail_cnt), exp_fail);

    attempt(5'b00001, 5'b00000, 5'b00001, 1'b0, 0);
    settle();
    chk("immediate_fail_busy", int'(busy_k1), 0);
    chk("immediate_fail_cnt", int'(fail_cnt), exp_fail);

    // seq2 dead at T0, seq1 dies at T0+1.
    attempt(5'b00001, 5'b00001, 5'b00001, 1'b0, 1);
    settle();
    chk("early_fail_cnt", int'(fail_cnt), exp_fail);
    chk("no_ovr_yet", int'(ovr), 0);

    // Second rise of start at T0+2 while running.
    attempt(5'b01101, 5'b00001, 5'b11000, 1'b1, 4);
    settle();
    chk("overrun_ovr", int'(ovr), 1);
    chk("overrun_pass_cnt", int'(pass_cnt), exp_pass);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    exp_pass = 0;
    exp_fail = 0;
    chk("clr_ovr", int'(ovr), 0);
    chk("clr_counts", int'({pass_cnt, fail_cnt}), 0);

    attempt(5'b00001, 5'b00011, 5'b00000, 1'b1, 1);
    settle();
    chk("pre_reset_pass_cnt", int'(pass_cnt), 1);

    // Reset lands at T0+2 of a seq2-live attempt; start stays high through release.
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b1;
    a     = 1'b0;
    b     = 1'b1;
    #1;
    chk("async_reset_outputs", int'({pass, fail, busy, ovr, pass_cnt, fail_cnt}), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    exp_pass = 0;
    exp_fail = 0;
    chk("held_start_no_trigger", int'({busy, pass_cnt, fail_cnt}), 0);
    settle();

    for (int i = 0; i < 260; i++) begin
      attempt(5'b00001, 5'b00011, 5'b00000, 1'b1, 1);
    end
    settle();
    chk("saturated_pass_cnt", int'(pass_cnt), 255);
    chk("saturated_fail_cnt", int'(fail_cnt), exp_fail);

    repeat (4) step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("scoreboard_empty", exp_q.size(), 0);
    chk("max_busy_run_le4", int'(max_run <= 4), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
